alu_pipe: RTL and testbench

Parametrised, pipelined ALU functional unit for the Tomasulo back end. It sits between an ALU reservation station and the CDB arbiter, and accepts one operation per cycle over a valid/ready handshake. Each result moves through a configurable-depth pipeline with per-stage valid bits and bubble collapsing, and is held on a CDB request until the arbiter grants it. Beyond add/shift/logic it executes slt/sltu and branch compares, and it supports a flush that kills all in-flight work.

---
 rtl/alu_pipe_pkg.sv | 46 ++++
 rtl/alu_pipe_if.sv | 36 +++
 rtl/alu_pipe_alu_core.sv | 78 +++++++
 rtl/alu_pipe.sv | 98 +++++++++
 tb/tb_alu_pipe.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: operation classes, decoded ALU operations
// and the RV32I funct3 encodings used by arithmetic and branch instructions.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        BRANCH = 3'd0,
        ARITH  = 3'd1,
        AUIPC  = 3'd2,
        JAL    = 3'd3,
        JALR   = 3'd4
    } op_t;

    typedef enum logic [3:0] {
        alu_add,
        alu_sub,
        alu_sll,
        alu_slt,
        alu_sltu,
        alu_xor,
        alu_srl,
        alu_sra,
        alu_or,
        alu_and
    } alu_ops;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        add  = 3'b000,
        sll  = 3'b001,
        slt  = 3'b010,
        sltu = 3'b011,
        axor = 3'b100,
        sr   = 3'b101,
        aor  = 3'b110,
        aand = 3'b111
    } arith_funct3_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Issue-side and CDB-side handshake bundle between the reservation station,
// the ALU pipeline and the CDB arbiter.
interface alu_pipe_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    import alu_pipe_pkg::*;

    logic              issue_valid;
    logic              issue_ready;
    op_t               issue_op;
    logic [2:0]        issue_funct3;
    logic              issue_funct7;
    logic [DATA_W-1:0] issue_src1;
    logic [DATA_W-1:0] issue_src2;
    logic [TAG_W-1:0]  issue_tag;

    logic              cdb_req;
    logic              cdb_grant;
    logic [DATA_W-1:0] cdb_data;
    logic [TAG_W-1:0]  cdb_tag;
    logic              cdb_br_taken;

    modport master (
        output issue_valid, issue_op, issue_funct3, issue_funct7,
               issue_src1, issue_src2, issue_tag, cdb_grant,
        input  issue_ready, cdb_req, cdb_data, cdb_tag, cdb_br_taken
    );

    modport slave (
        input  issue_valid, issue_op, issue_funct3, issue_funct7,
               issue_src1, issue_src2, issue_tag, cdb_grant,
        output issue_ready, cdb_req, cdb_data, cdb_tag, cdb_br_taken
    );

endinterface

// File: rtl/alu_pipe_alu_core.sv
// Combinational decode and compute for one ALU operation: arithmetic, shifts,
// logic, set-less-than and branch compares.
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  op_t               op_i,
    input  logic [2:0]        funct3_i,
    input  logic              funct7_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [DATA_W-1:0] result_o,
    output logic              brTaken_o
);
    localparam int SHW = $clog2(DATA_W);

    alu_ops          aluOp;
    logic [SHW-1:0]  shamt;
    logic            lessSigned;
    logic            lessUnsigned;
    logic            equal;

    assign shamt        = src2_i[SHW-1:0];
    assign lessSigned   = $signed(src1_i) < $signed(src2_i);
    assign lessUnsigned = src1_i < src2_i;
    assign equal        = src1_i == src2_i;

    always_comb begin
        aluOp = alu_add;
        case (arith_funct3_t'(funct3_i))
            add:  aluOp = funct7_i ? alu_sub : alu_add;
            sll:  aluOp = alu_sll;
            slt:  aluOp = alu_slt;
            sltu: aluOp = alu_sltu;
            axor: aluOp = alu_xor;
            sr:   aluOp = funct7_i ? alu_sra : alu_srl;
            aor:  aluOp = alu_or;
            aand: aluOp = alu_and;
        endcase
    end

    // Undefined branch funct3 encodings resolve to not-taken.
    always_comb begin
        brTaken_o = 1'b0;
        result_o  = src1_i + src2_i;
        case (op_i)
            BRANCH: begin
                case (branch_funct3_t'(funct3_i))
                    beq:     brTaken_o = equal;
                    bne:     brTaken_o = !equal;
                    blt:     brTaken_o = lessSigned;
                    bge:     brTaken_o = !lessSigned;
                    bltu:    brTaken_o = lessUnsigned;
                    bgeu:    brTaken_o = !lessUnsigned;
                    default: brTaken_o = 1'b0;
                endcase
                result_o = {{(DATA_W-1){1'b0}}, brTaken_o};
            end
            ARITH: begin
                case (aluOp)
                    alu_add:  result_o = src1_i + src2_i;
                    alu_sub:  result_o = src1_i - src2_i;
                    alu_sll:  result_o = src1_i << shamt;
                    alu_slt:  result_o = {{(DATA_W-1){1'b0}}, lessSigned};
                    alu_sltu: result_o = {{(DATA_W-1){1'b0}}, lessUnsigned};
                    alu_xor:  result_o = src1_i ^ src2_i;
                    alu_srl:  result_o = src1_i >> shamt;
                    alu_sra:  result_o = DATA_W'($signed(src1_i) >>> shamt);
                    alu_or:   result_o = src1_i | src2_i;
                    alu_and:  result_o = src1_i & src2_i;
                endcase
            end
            default: result_o = src1_i + src2_i;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU functional unit: computes at issue, then carries the result
// through STAGES collapsing registers to a held CDB request.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    alu_pipe_if.slave io,
    output logic      busy
);
    typedef struct packed {
        logic              valid;
        logic              brTaken;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } stage_t;

    stage_t            stage_q [STAGES];
    stage_t            stage_d [STAGES];
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] move;
    logic              accept;
    logic              broadcast;
    logic              issueReady;
    logic [DATA_W-1:0] coreResult;
    logic              coreBrTaken;

    alu_core #(.DATA_W(DATA_W)) u_core (
        .op_i      (io.issue_op),
        .funct3_i  (io.issue_funct3),
        .funct7_i  (io.issue_funct7),
        .src1_i    (io.issue_src1),
        .src2_i    (io.issue_src2),
        .result_o  (coreResult),
        .brTaken_o (coreBrTaken)
    );

    always_comb begin
        for (int i = 0; i < STAGES; i++) valid[i] = stage_q[i].valid;
    end

    assign broadcast  = valid[STAGES-1] && io.cdb_grant;
    assign issueReady = !valid[0] || move[0];
    assign accept     = io.issue_valid && issueReady;

    // A stage may advance if any later stage is empty or the tail is granted.
    always_comb begin : moveChain
        logic chain;
        chain = broadcast;
        move  = '0;
        for (int i = STAGES-1; i >= 0; i--) begin
            move[i] = chain;
            chain   = chain || !valid[i];
        end
    end

    always_comb begin
        stage_d = stage_q;
        for (int i = STAGES-1; i >= 1; i--) begin
            if (move[i-1] && valid[i-1]) begin
                stage_d[i] = stage_q[i-1];
            end else if (move[i]) begin
                stage_d[i].valid = 1'b0;
            end
        end
        if (accept) begin
            stage_d[0] = '{valid: 1'b1, brTaken: coreBrTaken,
                           tag: io.issue_tag, data: coreResult};
        end else if (move[0]) begin
            stage_d[0].valid = 1'b0;
        end
        // Flush kills everything, including the op accepted this cycle.
        if (flush) begin
            for (int i = 0; i < STAGES; i++) stage_d[i].valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign io.issue_ready  = issueReady;
    assign io.cdb_req      = stage_q[STAGES-1].valid;
    assign io.cdb_data     = stage_q[STAGES-1].data;
    assign io.cdb_tag      = stage_q[STAGES-1].tag;
    assign io.cdb_br_taken = stage_q[STAGES-1].brTaken;
    assign busy            = |valid;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe at STAGES=2: arithmetic, branches,
// back-pressure, flush and mid-stream reset.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int STAGES = 2;

    logic clk;
    logic rst;
    logic flush;
    logic busy;

    int checkCount;
    int passCount;

    alu_pipe_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    alu_pipe #(.DATA_W(DATA_W), .TAG_W(TAG_W), .STAGES(STAGES)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .io    (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input op_t op, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [3:0] tag);
        bus.issue_valid  = 1'b1;
        bus.issue_op     = op;
        bus.issue_funct3 = f3;
        bus.issue_funct7 = f7;
        bus.issue_src1   = s1;
        bus.issue_src2   = s2;
        bus.issue_tag    = tag;
    endtask

    task automatic idleIssue();
        bus.issue_valid = 1'b0;
    endtask

    // Issue one op with grant high and check the broadcast two cycles later.
    task automatic runOp(input string name, input op_t op, input logic [2:0] f3,
                         input logic f7, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [3:0] tag, input logic [31:0] expData,
                         input logic expBr);
        applyStimulus(op, f3, f7, s1, s2, tag);
        tick();
        idleIssue();
        tick();
        checkOutput({name, "_req"},  {31'd0, bus.cdb_req}, 32'd1);
        checkOutput({name, "_data"}, bus.cdb_data, expData);
        checkOutput({name, "_tag"},  {28'd0, bus.cdb_tag}, {28'd0, tag});
        checkOutput({name, "_br"},   {31'd0, bus.cdb_br_taken}, {31'd0, expBr});
        tick();
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst   = 1'b1;
        flush = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.issue_op     = ARITH;
        bus.issue_funct3 = 3'd0;
        bus.issue_funct7 = 1'b0;
        bus.issue_src1   = '0;
        bus.issue_src2   = '0;
        bus.issue_tag    = '0;
        bus.cdb_grant    = 1'b1;

        tick();
        tick();
        checkOutput("rst_req",   {31'd0, bus.cdb_req}, 32'd0);
        checkOutput("rst_data",  bus.cdb_data, 32'd0);
        checkOutput("rst_tag",   {28'd0, bus.cdb_tag}, 32'd0);
        checkOutput("rst_br",    {31'd0, bus.cdb_br_taken}, 32'd0);
        checkOutput("rst_busy",  {31'd0, busy}, 32'd0);
        checkOutput("rst_ready", {31'd0, bus.issue_ready}, 32'd1);
        rst = 1'b0;

        // Back-to-back add/sub with grant held high.
        applyStimulus(ARITH, 3'd0, 1'b0, 32'd5, 32'd7, 4'd3);
        tick();
        checkOutput("lat_req_early", {31'd0, bus.cdb_req}, 32'd0);
        applyStimulus(ARITH, 3'd0, 1'b1, 32'd5, 32'd7, 4'd4);
        tick();
        checkOutput("add_req",  {31'd0, bus.cdb_req}, 32'd1);
        checkOutput("add_data", bus.cdb_data, 32'd12);
        checkOutput("add_tag",  {28'd0, bus.cdb_tag}, 32'd3);
        idleIssue();
        tick();
        checkOutput("sub_req",  {31'd0, bus.cdb_req}, 32'd1);
        checkOutput("sub_data", bus.cdb_data, 32'hFFFF_FFFE);
        checkOutput("sub_tag",  {28'd0, bus.cdb_tag}, 32'd4);
        tick();
        checkOutput("drain_req",  {31'd0, bus.cdb_req}, 32'd0);
        checkOutput("drain_busy", {31'd0, busy}, 32'd0);

        runOp("slt",   ARITH,  3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd1, 32'd1, 1'b0);
        runOp("sltu",  ARITH,  3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd2, 32'd0, 1'b0);
        runOp("sra",   ARITH,  3'd5, 1'b1, 32'h8000_0000, 32'd4, 4'd5, 32'hF800_0000, 1'b0);
        runOp("srl",   ARITH,  3'd5, 1'b0, 32'h8000_0000, 32'd4, 4'd6, 32'h0800_0000, 1'b0);
        runOp("sllw",  ARITH,  3'd1, 1'b0, 32'd1, 32'd33, 4'd7, 32'd2, 1'b0);
        runOp("xor",   ARITH,  3'd4, 1'b0, 32'hF0F0, 32'hFF00, 4'd8, 32'h0FF0, 1'b0);
        runOp("or",    ARITH,  3'd6, 1'b0, 32'hF0F0, 32'hFF00, 4'd9, 32'hFFF0, 1'b0);
        runOp("and",   ARITH,  3'd7, 1'b0, 32'hF0F0, 32'hFF00, 4'd10, 32'hF000, 1'b0);
        runOp("blt",   BRANCH, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd0, 4'd11, 32'd1, 1'b1);
        runOp("bgeu",  BRANCH, 3'd7, 1'b0, 32'hFFFF_FFFF, 32'd0, 4'd12, 32'd1, 1'b1);
        runOp("beq",   BRANCH, 3'd0, 1'b0, 32'd3, 32'd4, 4'd13, 32'd0, 1'b0);
        runOp("auipc", AUIPC,  3'd0, 1'b0, 32'h1000, 32'h20, 4'd14, 32'h1020, 1'b0);
        runOp("jalr",  JALR,   3'd0, 1'b0, 32'hFFFF_FFFF, 32'd2, 4'd15, 32'd1, 1'b0);

        // Back-pressure: grant low, three ops offered.
        bus.cdb_grant = 1'b0;
        applyStimulus(ARITH, 3'd0, 1'b0, 32'd1, 32'd1, 4'd5);
        tick();
        applyStimulus(ARITH, 3'd0, 1'b0, 32'd2, 32'd2, 4'd6);
        #1;
        checkOutput("bp_ready_one", {31'd0, bus.issue_ready}, 32'd1);
        tick();
        applyStimulus(ARITH, 3'd0, 1'b0, 32'd3, 32'd3, 4'd7);
        #1;
        checkOutput("bp_ready_full", {31'd0, bus.issue_ready}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("bp_hold_req",  {31'd0, bus.cdb_req}, 32'd1);
            checkOutput("bp_hold_data", bus.cdb_data, 32'd2);
            checkOutput("bp_hold_tag",  {28'd0, bus.cdb_tag}, 32'd5);
            checkOutput("bp_hold_ready", {31'd0, bus.issue_ready}, 32'd0);
        end
        bus.cdb_grant = 1'b1;
        #1;
        checkOutput("bp_grant_ready", {31'd0, bus.issue_ready}, 32'd1);
        tick();
        idleIssue();
        checkOutput("bp_second_data", bus.cdb_data, 32'd4);
        checkOutput("bp_second_tag",  {28'd0, bus.cdb_tag}, 32'd6);
        tick();
        checkOutput("bp_third_data", bus.cdb_data, 32'd6);
        checkOutput("bp_third_tag",  {28'd0, bus.cdb_tag}, 32'd7);
        tick();
        checkOutput("bp_empty_req", {31'd0, bus.cdb_req}, 32'd0);

        // Flush with two in flight plus an accept in the same cycle.
        bus.cdb_grant = 1'b0;
        applyStimulus(ARITH, 3'd0, 1'b0, 32'd8, 32'd0, 4'd8);
        tick();
        applyStimulus(ARITH, 3'd0, 1'b0, 32'd9, 32'd0, 4'd9);
        tick();
        applyStimulus(ARITH, 3'd0, 1'b0, 32'd10, 32'd0, 4'd10);
        bus.cdb_grant = 1'b1;
        flush = 1'b1;
        #1;
        checkOutput("fl_ready_in", {31'd0, bus.issue_ready}, 32'd1);
        tick();
        flush = 1'b0;
        idleIssue();
        checkOutput("fl_busy",  {31'd0, busy}, 32'd0);
        checkOutput("fl_req",   {31'd0, bus.cdb_req}, 32'd0);
        checkOutput("fl_ready", {31'd0, bus.issue_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("fl_no_stale", {31'd0, bus.cdb_req}, 32'd0);
        end

        // Reset mid-stream with grant high.
        applyStimulus(BRANCH, 3'd1, 1'b0, 32'd1, 32'd2, 4'd11);
        tick();
        applyStimulus(ARITH, 3'd0, 1'b0, 32'd4, 32'd4, 4'd12);
        tick();
        checkOutput("mr_pre_br", {31'd0, bus.cdb_br_taken}, 32'd1);
        applyStimulus(ARITH, 3'd0, 1'b0, 32'd5, 32'd5, 4'd13);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idleIssue();
        checkOutput("mr_req",   {31'd0, bus.cdb_req}, 32'd0);
        checkOutput("mr_data",  bus.cdb_data, 32'd0);
        checkOutput("mr_tag",   {28'd0, bus.cdb_tag}, 32'd0);
        checkOutput("mr_br",    {31'd0, bus.cdb_br_taken}, 32'd0);
        checkOutput("mr_busy",  {31'd0, busy}, 32'd0);
        checkOutput("mr_ready", {31'd0, bus.issue_ready}, 32'd1);
        applyStimulus(ARITH, 3'd0, 1'b0, 32'd9, 32'd9, 4'd14);
        tick();
        idleIssue();
        checkOutput("mr_lat_early", {31'd0, bus.cdb_req}, 32'd0);
        tick();
        checkOutput("mr_first_req",  {31'd0, bus.cdb_req}, 32'd1);
        checkOutput("mr_first_data", bus.cdb_data, 32'd18);
        checkOutput("mr_first_tag",  {28'd0, bus.cdb_tag}, 32'd14);
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
